ddr_init_seq: RTL and testbench
===============================

Name: ddr_init_seq

Overview:
- Hardware power-up sequencer for the DDR SDRAM controller. Replaces the software CSR write sequence.
- Sits between the WISHBONE-to-CSR bridge and the ddram CSR port. While initialising, it owns the CSR bus and issues the JEDEC init writes (bypass, precharge, EMR/MR loads, auto-refresh) with the required gaps.
- When finished, it hands the CSR bus back to the bridge as a pass-through.

Parameters:
- csr_addr, 4'h2: CSR bank of the DDR controller; driven on csr_a[13:10].
- POWERUP_CYCLES, 20000: sys_clk cycles of idle wait before the first write (minimum 1).
- DLL_WAIT, 200: gap after each Load Mode Register write (entries 7 and 15), in cycles (minimum 1).
- AUTO_START, 1: 1 = sequence starts after reset release; 0 = waits for start.

Ports:
- sys_clk  in  1  system clock
- sys_rst_n  in  1  asynchronous, active-low reset
- start  in  1  single-cycle start pulse; used only when AUTO_START=0
- ext_csr_a  in  14  CSR address from csrbrg
- ext_csr_we  in  1  CSR write strobe from csrbrg
- ext_csr_do  in  32  CSR write data from csrbrg
- csr_a  out  14  CSR address to ddram
- csr_we  out  1  CSR write strobe to ddram
- csr_do  out  32  CSR write data to ddram
- busy  out  1  sequencer owns the CSR bus
- done  out  1  sequence complete; bus handed back
- step  out  5  index of current table entry (debug)
- ext_drop  out  8  saturating count of external writes dropped while busy

Behaviour:
- Reset values: state IDLE; busy=0, done=0, step=0, ext_drop=0, all counters 0. Engine csr registers are 0.
- States and transitions:
  - IDLE: if AUTO_START, go to POWERUP on the first clock after reset release. Otherwise go to POWERUP on the cycle after start=1.
  - POWERUP: busy=1. Counter runs POWERUP_CYCLES cycles, then WRITE.
  - WRITE: exactly one cycle with csr_we=1, csr_a={csr_addr,6'd0,reg[3:0]}, csr_do=data[step]. Then WAIT.
  - WAIT: stays for gap[step] cycles, so consecutive csr_we pulses are gap+1 cycles apart. At the end, if step==17 go to DONE; else step+1 and go to WRITE.
  - DONE: busy=0, done=1. Terminal until reset.
- Sequence table, 18 entries of (reg, data, gap):
  - 0: (0, 0x1, 1)
  - 1: (3, 0x1, 1)
  - 2: (0, 0x7, 1)
  - 3: (1, 0x400b, 1)
  - 4: (1, 0x8, 1)
  - 5: (1, 0x2000f, 1)
  - 6: (1, 0x8, 1)
  - 7: (1, 0x123f, DLL_WAIT)
  - 8: (1, 0x8, 1)
  - 9: (1, 0x400b, 1)
  - 10: (1, 0x8, 1)
  - 11: (1, 0xd, 4)
  - 12: (1, 0x8, 1)
  - 13: (1, 0xd, 4)
  - 14: (1, 0x8, 1)
  - 15: (1, 0x21f, DLL_WAIT)
  - 16: (1, 0x8, 1)
  - 17: (0, 0x4, 1)
- Bus mux:
  - While busy=1: outputs come from the registered engine; csr_we=0 outside WRITE; csr_a and csr_do hold their last values.
  - While busy=0 (IDLE or DONE): outputs equal the ext_* inputs combinationally, with zero latency.
- Dropped writes: ext_csr_we=1 while busy=1 is discarded and ext_drop increments, saturating at 255. In the cycle busy falls, external writes pass through and are not counted.
- start: ignored outside IDLE and ignored when AUTO_START=1.
- Reset mid-sequence: asserting sys_rst_n low aborts immediately. All outputs return to reset values and the sequence restarts from POWERUP and entry 0.
- Counter widths: 16-bit gap counter, sized to hold max(POWERUP_CYCLES, DLL_WAIT).

Optional Feature:
- Macro: DDR_INIT_RESTART_EN.
- Defined:
  - start=1 in DONE clears done, sets busy, resets step to 0, and reruns the sequence from POWERUP.
  - ext_drop is not cleared.
- Undefined: DONE is terminal; start has no effect outside IDLE.

Test Plan:
- Auto start (POWERUP_CYCLES=16, DLL_WAIT=8): release reset at cycle 0.
  - First csr_we at cycle 17 with csr_a=0x800, csr_do=0x1.
  - Then 18 write pulses total in table order.
  - Pulse 8 (0x123f) is followed by a 9-cycle gap before pulse 9.
  - done=1 after the last WAIT.
- Gap check: exactly 5 cycles between the csr_we pulses carrying 0xd and the following 0x8. The pulse carrying 0x2000f has csr_a=0x801.
- Contention: drive ext_csr_we=1 for 3 cycles during POWERUP.
  - ddram sees no write; ext_drop=3.
  - After done, ext write (0x802, 0xabadface) appears on csr_a/csr_do in the same cycle.
- Saturation: 300 ext writes while busy -> ext_drop=255.
- Reset mid-sequence at step 9: outputs reset immediately; after release, the first write is again (0x800, 0x1) after POWERUP_CYCLES.
- AUTO_START=0: no write for 100 cycles. Pulse start -> POWERUP begins next cycle.
  - With DDR_INIT_RESTART_EN, start in DONE reruns all 18 writes.
  - Without it, start in DONE produces no writes.

Source files
------------

// File: rtl/ddr_init_seq.sv
// -----------------------------------------------------------------------------
// ddr_init_seq
// Power-up sequencer for the DDR SDRAM controller CSR port. After reset (or a
// start pulse when AUTO_START=0) it owns the CSR bus, waits POWERUP_CYCLES, then
// plays an 18-entry table of CSR writes (bypass, precharge, EMR/MR loads,
// auto-refresh) with a per-entry gap. When the table is finished, the CSR bus
// becomes a zero-latency pass-through from the WISHBONE-to-CSR bridge.
//
// Optional feature macro: DDR_INIT_RESTART_EN
//   defined   : start=1 while done reruns the sequence from POWERUP, entry 0
//               (the dropped-write counter is kept).
//   undefined : done is terminal until reset.
//
// Ports
//   sys_clk, sys_rst_n   clock, asynchronous active-low reset
//   start                start pulse (AUTO_START=0, or restart when enabled)
//   ext_csr_a/we/do      CSR request from the bridge
//   csr_a/we/do          CSR request to the DDR controller
//   busy                 sequencer owns the CSR bus
//   done                 sequence complete, bus handed back
//   step                 current table entry (debug)
//   ext_drop             saturating count of bridge writes dropped while busy
// -----------------------------------------------------------------------------
module ddr_init_seq #(
    parameter logic [3:0] csr_addr       = 4'h2,
    parameter int         POWERUP_CYCLES = 20000,
    parameter int         DLL_WAIT       = 200,
    parameter bit         AUTO_START     = 1'b1
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic        start,
    input  logic [13:0] ext_csr_a,
    input  logic        ext_csr_we,
    input  logic [31:0] ext_csr_do,
    output logic [13:0] csr_a,
    output logic        csr_we,
    output logic [31:0] csr_do,
    output logic        busy,
    output logic        done,
    output logic [4:0]  step,
    output logic [7:0]  ext_drop
);

    localparam logic [4:0]  LAST_STEP = 5'd17;
    // Counters compare against "cycles - 1" so a value of N gives N cycles.
    localparam logic [15:0] PU_LAST   = 16'(POWERUP_CYCLES - 1);
    localparam logic [15:0] DLL_LAST  = 16'(DLL_WAIT - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_POWERUP,
        ST_WRITE,
        ST_WAIT,
        ST_DONE
    } state_t;

    state_t      r_state;
    logic [15:0] r_cnt;
    logic [4:0]  r_step;
    logic        r_busy;
    logic        r_done;
    logic        r_csr_we;
    logic [13:0] r_csr_a;
    logic [31:0] r_csr_do;
    logic [7:0]  r_drop;

    logic        w_start_go;
    logic [4:0]  w_next_step;

    // CSR register index for each table entry.
    function automatic logic [3:0] f_reg(input logic [4:0] idx);
        case (idx)
            5'd0, 5'd2, 5'd17: f_reg = 4'd0;
            5'd1:              f_reg = 4'd3;
            default:           f_reg = 4'd1;
        endcase
    endfunction

    // Write data for each table entry.
    function automatic logic [31:0] f_data(input logic [4:0] idx);
        case (idx)
            5'd0, 5'd1:   f_data = 32'h0000_0001;
            5'd2:         f_data = 32'h0000_0007;
            5'd3, 5'd9:   f_data = 32'h0000_400b;
            5'd5:         f_data = 32'h0002_000f;
            5'd7:         f_data = 32'h0000_123f;
            5'd11, 5'd13: f_data = 32'h0000_000d;
            5'd15:        f_data = 32'h0000_021f;
            5'd17:        f_data = 32'h0000_0004;
            default:      f_data = 32'h0000_0008;
        endcase
    endfunction

    // Terminal count of the WAIT gap following each entry (gap - 1).
    // Entries 7 and 15 are mode-register loads and need the DLL lock time.
    function automatic logic [15:0] f_gap_last(input logic [4:0] idx);
        case (idx)
            5'd7, 5'd15:  f_gap_last = DLL_LAST;
            5'd11, 5'd13: f_gap_last = 16'd3;
            default:      f_gap_last = 16'd0;
        endcase
    endfunction

    assign w_start_go  = AUTO_START ? 1'b1 : start;
    assign w_next_step = r_step + 5'd1;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state  <= ST_IDLE;
            r_cnt    <= 16'd0;
            r_step   <= 5'd0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_csr_we <= 1'b0;
            r_csr_a  <= 14'd0;
            r_csr_do <= 32'd0;
            r_drop   <= 8'd0;
        end else begin
            // Bridge writes that arrive while we own the bus are lost; count them.
            if (ext_csr_we && r_busy && (r_drop != 8'hFF)) begin
                r_drop <= r_drop + 8'd1;
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_start_go) begin
                        r_state <= ST_POWERUP;
                        r_busy  <= 1'b1;
                        r_cnt   <= 16'd0;
                    end
                end

                ST_POWERUP: begin
                    if (r_cnt == PU_LAST) begin
                        r_state  <= ST_WRITE;
                        r_csr_we <= 1'b1;
                        r_csr_a  <= {csr_addr, 6'd0, f_reg(r_step)};
                        r_csr_do <= f_data(r_step);
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end

                ST_WRITE: begin
                    // Single-cycle strobe; address/data stay on the bus.
                    r_csr_we <= 1'b0;
                    r_cnt    <= 16'd0;
                    r_state  <= ST_WAIT;
                end

                ST_WAIT: begin
                    if (r_cnt == f_gap_last(r_step)) begin
                        if (r_step == LAST_STEP) begin
                            r_state <= ST_DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end else begin
                            // Load the next entry so the strobe leaves a register.
                            r_step   <= w_next_step;
                            r_state  <= ST_WRITE;
                            r_csr_we <= 1'b1;
                            r_csr_a  <= {csr_addr, 6'd0, f_reg(w_next_step)};
                            r_csr_do <= f_data(w_next_step);
                        end
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end

                ST_DONE: begin
`ifdef DDR_INIT_RESTART_EN
                    if (start) begin
                        r_state <= ST_POWERUP;
                        r_busy  <= 1'b1;
                        r_done  <= 1'b0;
                        r_step  <= 5'd0;
                        r_cnt   <= 16'd0;
                    end
`endif
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Bus mux: engine while busy, otherwise combinational pass-through.
    assign csr_we   = r_busy ? r_csr_we : ext_csr_we;
    assign csr_a    = r_busy ? r_csr_a  : ext_csr_a;
    assign csr_do   = r_busy ? r_csr_do : ext_csr_do;

    assign busy     = r_busy;
    assign done     = r_done;
    assign step     = r_step;
    assign ext_drop = r_drop;

endmodule

// File: tb/tb_ddr_init_seq.sv
// -----------------------------------------------------------------------------
// tb_ddr_init_seq
// Self-checking bench for ddr_init_seq. Instance A (auto start, short power-up)
// is checked every cycle against a schedule computed from the write table;
// instance B (start-driven, long power-up) covers start handling, drop-counter
// saturation and the optional restart.
// -----------------------------------------------------------------------------
module tb_ddr_init_seq;

    localparam int PU   = 16;
    localparam int PU_B = 320;
    localparam int DW   = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- DUT A ----------------
    logic        a_rst_n, a_start, a_ext_we, a_csr_we, a_busy, a_done;
    logic [13:0] a_ext_a, a_csr_a;
    logic [31:0] a_ext_do, a_csr_do;
    logic [4:0]  a_step;
    logic [7:0]  a_drop;

    ddr_init_seq #(.csr_addr(4'h2), .POWERUP_CYCLES(PU), .DLL_WAIT(DW), .AUTO_START(1'b1)) u_dut_a (
        .sys_clk(clk), .sys_rst_n(a_rst_n), .start(a_start),
        .ext_csr_a(a_ext_a), .ext_csr_we(a_ext_we), .ext_csr_do(a_ext_do),
        .csr_a(a_csr_a), .csr_we(a_csr_we), .csr_do(a_csr_do),
        .busy(a_busy), .done(a_done), .step(a_step), .ext_drop(a_drop)
    );

    // ---------------- DUT B ----------------
    logic        b_rst_n, b_start, b_ext_we, b_csr_we, b_busy, b_done;
    logic [13:0] b_ext_a, b_csr_a;
    logic [31:0] b_ext_do, b_csr_do;
    logic [4:0]  b_step;
    logic [7:0]  b_drop;

    ddr_init_seq #(.csr_addr(4'h2), .POWERUP_CYCLES(PU_B), .DLL_WAIT(DW), .AUTO_START(1'b0)) u_dut_b (
        .sys_clk(clk), .sys_rst_n(b_rst_n), .start(b_start),
        .ext_csr_a(b_ext_a), .ext_csr_we(b_ext_we), .ext_csr_do(b_ext_do),
        .csr_a(b_csr_a), .csr_we(b_csr_we), .csr_do(b_csr_do),
        .busy(b_busy), .done(b_done), .step(b_step), .ext_drop(b_drop)
    );

    // ---------------- reference tables ----------------
    typedef struct {
        logic [13:0] a;
        logic [31:0] d;
        int          gap;
    } wr_t;

    typedef struct {
        logic [13:0] ea;
        logic        ewe;
        logic [31:0] ed;
        logic [13:0] xa;
        logic        xwe;
        logic [31:0] xd;
    } pt_t;

    typedef struct {
        int          c;
        logic [13:0] a;
        logic [31:0] d;
    } rec_t;

    wr_t  tbl[18];
    int   wrel[18];   // write offsets relative to the first write
    pt_t  pt[4];
    rec_t b_q[$];

    // Records every engine-driven strobe seen at DUT B's CSR output.
    always begin
        @(negedge clk);
        #2;
        if (b_busy && b_csr_we) b_q.push_back('{c: cyc, a: b_csr_a, d: b_csr_do});
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Drives one full auto-start sequence on A from reset release (entered at a
    // negedge with reset asserted). mode 0: 3 bridge writes during power-up;
    // mode 1: random bridge traffic throughout.
    task automatic run_a(input int mode);
        int wcyc[18];
        int done_c;
        int drops;
        int widx;
        int nw;
        bit exp_busy;
        bit exp_done;
        for (int i = 0; i < 18; i++) wcyc[i] = 1 + PU + wrel[i];
        done_c = wcyc[17] + tbl[17].gap + 1;
        drops  = 0;
        a_rst_n = 1'b1;
        for (int c = 0; c <= done_c + 3; c++) begin
            a_ext_a  = 14'($urandom);
            a_ext_do = $urandom;
            if (mode == 0) a_ext_we = (c >= 3 && c <= 5);
            else           a_ext_we = ($urandom_range(0, 2) == 0);
            #1;
            exp_busy = (c >= 1 && c < done_c);
            exp_done = (c >= done_c);
            widx = -1;
            nw   = 0;
            for (int i = 0; i < 18; i++) begin
                if (wcyc[i] == c) widx = i;
                if (wcyc[i] <= c) nw++;
            end
            chk("a_busy", a_busy, exp_busy);
            chk("a_done", a_done, exp_done);
            chk("a_step", a_step, (nw == 0) ? 0 : nw - 1);
            chk("a_ext_drop", a_drop, drops);
            if (exp_busy) begin
                chk("a_csr_we_engine", a_csr_we, (widx >= 0));
                if (widx >= 0) begin
                    $display("A write %0d at cycle %0d: csr_a=0x%h csr_do=0x%h", widx, c, a_csr_a, a_csr_do);
                    chk("a_csr_a_engine", a_csr_a, tbl[widx].a);
                    chk("a_csr_do_engine", a_csr_do, tbl[widx].d);
                end
            end else begin
                chk("a_csr_we_pass", a_csr_we, a_ext_we);
                chk("a_csr_a_pass", a_csr_a, a_ext_a);
                chk("a_csr_do_pass", a_csr_do, a_ext_do);
            end
            if (exp_busy && a_ext_we) drops = (drops < 255) ? drops + 1 : 255;
            @(negedge clk);
        end
        a_ext_we = 1'b0;
    endtask

    // Compares B's recorded strobes with the table, first write expected at cycle s+1+PU_B.
    task automatic check_b_writes(input int s, input string tag);
        chk({tag, "_write_count"}, b_q.size(), 18);
        for (int i = 0; i < 18 && i < b_q.size(); i++) begin
            $display("B %s write %0d at cycle %0d: csr_a=0x%h csr_do=0x%h", tag, i, b_q[i].c, b_q[i].a, b_q[i].d);
            chk({tag, "_write_cycle"}, b_q[i].c, s + 1 + PU_B + wrel[i]);
            chk({tag, "_write_a"}, b_q[i].a, tbl[i].a);
            chk({tag, "_write_d"}, b_q[i].d, tbl[i].d);
        end
    endtask

    initial begin
        int s;
        int k;

        // Write table: (reg, data, gap); address = bank 2 << 10 | reg.
        tbl[0]  = '{14'h800, 32'h1,     1};
        tbl[1]  = '{14'h803, 32'h1,     1};
        tbl[2]  = '{14'h800, 32'h7,     1};
        tbl[3]  = '{14'h801, 32'h400b,  1};
        tbl[4]  = '{14'h801, 32'h8,     1};
        tbl[5]  = '{14'h801, 32'h2000f, 1};
        tbl[6]  = '{14'h801, 32'h8,     1};
        tbl[7]  = '{14'h801, 32'h123f,  DW};
        tbl[8]  = '{14'h801, 32'h8,     1};
        tbl[9]  = '{14'h801, 32'h400b,  1};
        tbl[10] = '{14'h801, 32'h8,     1};
        tbl[11] = '{14'h801, 32'hd,     4};
        tbl[12] = '{14'h801, 32'h8,     1};
        tbl[13] = '{14'h801, 32'hd,     4};
        tbl[14] = '{14'h801, 32'h8,     1};
        tbl[15] = '{14'h801, 32'h21f,   DW};
        tbl[16] = '{14'h801, 32'h8,     1};
        tbl[17] = '{14'h800, 32'h4,     1};
        wrel[0] = 0;
        for (int i = 1; i < 18; i++) wrel[i] = wrel[i-1] + tbl[i-1].gap + 1;

        // Pass-through vectors applied after done (zero-latency expected).
        pt[0] = '{14'h802,  1'b1, 32'habadface, 14'h802,  1'b1, 32'habadface};
        pt[1] = '{14'h000,  1'b0, 32'h0,        14'h000,  1'b0, 32'h0};
        pt[2] = '{14'h3fff, 1'b1, 32'hffffffff, 14'h3fff, 1'b1, 32'hffffffff};
        pt[3] = '{14'h805,  1'b0, 32'h12345678, 14'h805,  1'b0, 32'h12345678};

        a_rst_n = 1'b0; a_start = 1'b0; a_ext_we = 1'b0; a_ext_a = '0; a_ext_do = '0;
        b_rst_n = 1'b0; b_start = 1'b0; b_ext_we = 1'b0; b_ext_a = '0; b_ext_do = '0;
        repeat (3) @(negedge clk);
        #1;
        chk("a_reset_busy", a_busy, 0);
        chk("a_reset_done", a_done, 0);
        chk("a_reset_step", a_step, 0);
        chk("a_reset_drop", a_drop, 0);
        chk("a_reset_we", a_csr_we, 0);
        @(negedge clk);

        // A: auto start with contention during power-up, then pass-through.
        run_a(0);
        chk("a_contention_drop", a_drop, 3);
        for (int i = 0; i < 4; i++) begin
            a_ext_a = pt[i].ea; a_ext_we = pt[i].ewe; a_ext_do = pt[i].ed;
            #1;
            $display("A pass-through vector %0d: csr_a=0x%h we=%0b csr_do=0x%h", i, a_csr_a, a_csr_we, a_csr_do);
            chk("a_pt_a", a_csr_a, pt[i].xa);
            chk("a_pt_we", a_csr_we, pt[i].xwe);
            chk("a_pt_do", a_csr_do, pt[i].xd);
            chk("a_pt_drop_hold", a_drop, 3);
            @(negedge clk);
        end
        a_ext_we = 1'b0;

        // A: reset mid-sequence at entry 9, then a random-traffic full run.
        a_rst_n = 1'b0;
        @(negedge clk);
        a_rst_n = 1'b1;
        k = 0;
        while (k < 400 && a_step != 5'd9) begin
            @(negedge clk);
            k++;
        end
        chk("a_reach_step9", a_step, 9);
        #2 a_rst_n = 1'b0;
        #1;
        chk("a_midreset_busy", a_busy, 0);
        chk("a_midreset_done", a_done, 0);
        chk("a_midreset_step", a_step, 0);
        chk("a_midreset_we", a_csr_we, 0);
        @(negedge clk);
        @(negedge clk);
        run_a(1);

        // B: no activity without start.
        b_rst_n = 1'b1;
        k = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            #1;
            if (b_busy || b_csr_we) k++;
        end
        chk("b_idle_quiet", k, 0);
        chk("b_idle_no_writes", b_q.size(), 0);

        // B: start pulse, power-up begins the next cycle; saturate drop counter.
        b_start = 1'b1;
        s = cyc;
        @(negedge clk);
        b_start = 1'b0;
        #1;
        chk("b_busy_after_start", b_busy, 1);
        b_ext_we = 1'b1;
        repeat (300) @(negedge clk);
        b_ext_we = 1'b0;
        #1;
        chk("b_drop_saturated", b_drop, 255);
        chk("b_no_write_in_powerup", b_q.size(), 0);
        k = 0;
        while (k < 2000 && !b_done) begin
            @(negedge clk);
            k++;
        end
        #1;
        chk("b_done", b_done, 1);
        check_b_writes(s, "b_first");
        chk("b_drop_kept", b_drop, 255);

        // B: start while done.
        b_q.delete();
        @(negedge clk);
        #1;
        b_start = 1'b1;
        s = cyc;
        @(negedge clk);
        b_start = 1'b0;
        #1;
`ifdef DDR_INIT_RESTART_EN
        chk("b_restart_busy", b_busy, 1);
        chk("b_restart_done_clr", b_done, 0);
        chk("b_restart_step", b_step, 0);
        k = 0;
        while (k < 2000 && !b_done) begin
            @(negedge clk);
            k++;
        end
        #1;
        chk("b_restart_done", b_done, 1);
        check_b_writes(s, "b_rerun");
        chk("b_restart_drop_kept", b_drop, 255);
`else
        repeat (500) @(negedge clk);
        #1;
        chk("b_done_terminal_writes", b_q.size(), 0);
        chk("b_done_terminal_done", b_done, 1);
        chk("b_done_terminal_busy", b_busy, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, required completion");
        $fatal(1, "watchdog");
    end

endmodule
